stepper_pulse_gen: RTL

Dual-axis step/direction pulse generator sitting directly downstream of the joint-angle-to-steps conversion stage. It captures a pair of 9-bit unsigned step counts and direction bits on a one-cycle load strobe, which is the conversion stage's data-ready. It then emits a fixed-rate, fixed-width step pulse train on each axis toward the external stepper drivers. It also tracks a signed absolute step position per axis and reports completion with a one-cycle done pulse.

---
 rtl/stepper_pulse_gen_pkg.sv | 7 +
 rtl/stepper_pulse_gen_axis.sv | 47 ++++
 rtl/stepper_pulse_gen.sv | 117 +++++++++++
 3 files changed

// File: rtl/stepper_pulse_gen_pkg.sv
// Shared types and widths for the dual-axis step/direction pulse generator.
package stepper_pkg;
  localparam int STEP_CNT_W = 9;
  localparam int POS_W      = 16;

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;
endpackage

// File: rtl/stepper_pulse_gen_axis.sv
// One axis: remaining step counter, direction register, step output and
// two's-complement position accumulator, sequenced by the top-level FSM.
module stepper_axis
  import stepper_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture,
  input  logic                  fire,
  input  logic                  clear,
  input  logic                  step_end,
  input  logic [STEP_CNT_W-1:0] steps,
  input  logic                  dir,
  output logic                  step_out,
  output logic                  dir_out,
  output logic [POS_W-1:0]      pos,
  output logic                  active
);
  logic [STEP_CNT_W-1:0] rem;

  assign active = |rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      rem      <= '0;
      dir_out  <= 1'b0;
      step_out <= 1'b0;
      pos      <= '0;
    end else if (clear) begin
      rem      <= '0;
      step_out <= 1'b0;
    end else begin
      if (capture) begin
        rem     <= steps;
        dir_out <= dir;
      end
      // Axes that have finished stay low while the longer axis keeps pulsing.
      if (fire && active) begin
        step_out <= 1'b1;
        rem      <= rem - STEP_CNT_W'(1);
        pos      <= dir_out ? pos + POS_W'(1) : pos - POS_W'(1);
      end else if (step_end) begin
        step_out <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/stepper_pulse_gen.sv
// Dual-axis step/direction pulse generator: one shared phase timer drives
// both axes through SETUP / HIGH / LOW phases until both counts run out.
module stepper_pulse_gen
  import stepper_pkg::*;
#(
  parameter int STEP_PERIOD = 50000,
  parameter int PULSE_WIDTH = 100,
  parameter int DIR_SETUP   = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [STEP_CNT_W-1:0]   steps1,
  input  logic [STEP_CNT_W-1:0]   steps2,
  input  logic                    dir1,
  input  logic                    dir2,
  input  logic                    abort,
  output logic                    step1_out,
  output logic                    step2_out,
  output logic                    dir1_out,
  output logic                    dir2_out,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun,
  output logic signed [POS_W-1:0] pos1,
  output logic signed [POS_W-1:0] pos2
);
  localparam int TMR_MAX = (STEP_PERIOD > DIR_SETUP) ? STEP_PERIOD : DIR_SETUP;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] SETUP_END = TW'(DIR_SETUP - 1);
  localparam logic [TW-1:0] HIGH_END  = TW'(PULSE_WIDTH - 1);
  localparam logic [TW-1:0] LOW_END   = TW'(STEP_PERIOD - PULSE_WIDTH - 1);

  state_t                     state;
  logic [TW-1:0]              tmr;
  logic [1:0]                 rem_nz;
  logic                       any_rem;
  logic                       capture, fire, clear, step_end;
  logic [1:0][STEP_CNT_W-1:0] steps_v;
  logic [1:0]                 dir_v, step_v, dir_o;
  logic [1:0][POS_W-1:0]      pos_v;

  assign any_rem  = |rem_nz;
  assign capture  = (state == IDLE) && load && !abort;
  assign fire     = !abort && (((state == SETUP) && (tmr == SETUP_END)) ||
                               ((state == LOW)   && (tmr == LOW_END)));
  assign step_end = (state == HIGH) && (tmr == HIGH_END);
  assign clear    = abort && (state != IDLE);

  assign steps_v = {steps2, steps1};
  assign dir_v   = {dir2, dir1};

  for (genvar i = 0; i < 2; i++) begin : g_axis
    stepper_axis u_axis (
      .clk      (clk),
      .reset    (reset),
      .capture  (capture),
      .fire     (fire),
      .clear    (clear),
      .step_end (step_end),
      .steps    (steps_v[i]),
      .dir      (dir_v[i]),
      .step_out (step_v[i]),
      .dir_out  (dir_o[i]),
      .pos      (pos_v[i]),
      .active   (rem_nz[i])
    );
  end

  assign step1_out = step_v[0];
  assign step2_out = step_v[1];
  assign dir1_out  = dir_o[0];
  assign dir2_out  = dir_o[1];
  assign pos1      = pos_v[0];
  assign pos2      = pos_v[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tmr     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= load && (state != IDLE);
      tmr     <= tmr + TW'(1);
      if (state == IDLE) begin
        tmr <= '0;
        if (capture) begin
          state <= SETUP;
          busy  <= 1'b1;
        end
      end else if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          SETUP, LOW: if (fire) begin
            tmr   <= '0;
            state <= any_rem ? HIGH : DONE;
            done  <= !any_rem;
          end
          HIGH: if (step_end) begin
            tmr   <= '0;
            state <= LOW;
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
